// File: rtl/mac_acc_array.sv
// ============================================================================
// Module   : mac_acc_array
// Purpose  : Multi-beat accumulating MAC array, y(j) = sum_beats sum_i x(i)*w(i,j),
//            with the result held under a valid/ack handshake.
//            Define MAC_SAT_EN for saturating accumulation with sticky sat_flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc_array #(
    parameter int N_IN        = 4,
    parameter int N_OUT       = 4,
    parameter int MAC_IN_SIZE = 5,
    parameter int W_SIZE      = 5,
    parameter int ACC_SIZE    = 16,
    parameter int MAX_BEATS   = 8,
    localparam int CW         = $clog2(MAX_BEATS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_ready,
    output logic                            in_accept,
    input  logic [CW-1:0]                   num_beats,
    input  logic [N_IN*MAC_IN_SIZE-1:0]     x_flat,
    input  logic [N_IN*N_OUT*W_SIZE-1:0]    w_flat,
    output logic [N_OUT*ACC_SIZE-1:0]       out_flat,
    output logic                            mac_ready,
    input  logic                            out_ack,
    output logic [N_OUT-1:0]                sat_flag
);

    localparam int C_PROD_W = MAC_IN_SIZE + W_SIZE;
    localparam int C_SUM_W  = C_PROD_W + $clog2(N_IN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [CW-1:0]               r_cnt;
    logic [CW-1:0]               r_n;
    logic [CW-1:0]               w_n_sel;
    logic signed [ACC_SIZE-1:0]  r_acc  [N_OUT];
    logic signed [ACC_SIZE-1:0]  r_out  [N_OUT];
    logic signed [ACC_SIZE-1:0]  w_next [N_OUT];
    logic signed [C_PROD_W-1:0]  w_x    [N_IN];
    logic signed [C_PROD_W-1:0]  w_w    [N_IN][N_OUT];
    logic signed [C_PROD_W-1:0]  w_prod [N_IN][N_OUT];
    logic signed [C_SUM_W-1:0]   w_beat [N_OUT];
    logic                        w_take;
    logic                        w_to_done;

    // Operands are widened to the product width so each multiply is full precision.
    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign w_x[i] = C_PROD_W'($signed(x_flat[i*MAC_IN_SIZE +: MAC_IN_SIZE]));
        for (genvar j = 0; j < N_OUT; j++) begin : g_w
            assign w_w[i][j]    = C_PROD_W'($signed(w_flat[(i*N_OUT+j)*W_SIZE +: W_SIZE]));
            assign w_prod[i][j] = w_x[i] * w_w[i][j];
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            w_beat[j] = '0;
            for (int i = 0; i < N_IN; i++) begin
                w_beat[j] = w_beat[j] + C_SUM_W'(w_prod[i][j]);
            end
        end
    end

`ifdef MAC_SAT_EN
    localparam int C_EXT_W = ((C_SUM_W > ACC_SIZE) ? C_SUM_W : ACC_SIZE) + 1;

    logic [N_OUT-1:0] r_sat;
    logic [N_OUT-1:0] w_clamp;

    // Extra headroom bit lets overflow be detected from the top bits alone.
    for (genvar j = 0; j < N_OUT; j++) begin : g_sat
        logic signed [C_EXT_W-1:0] w_base;
        logic signed [C_EXT_W-1:0] w_sum;
        logic [C_EXT_W-ACC_SIZE:0] w_top;
        assign w_base     = (r_state == S_IDLE) ? {C_EXT_W{1'b0}} : C_EXT_W'(r_acc[j]);
        assign w_sum      = w_base + C_EXT_W'(w_beat[j]);
        assign w_top      = w_sum[C_EXT_W-1:ACC_SIZE-1];
        assign w_clamp[j] = ~((&w_top) | ~(|w_top));
        assign w_next[j]  = !w_clamp[j] ? w_sum[ACC_SIZE-1:0] :
                            w_sum[C_EXT_W-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}} :
                                               {1'b0, {(ACC_SIZE-1){1'b1}}};
    end

    assign sat_flag = r_sat;
`else
    for (genvar j = 0; j < N_OUT; j++) begin : g_wrap
        logic signed [ACC_SIZE-1:0] w_base;
        assign w_base    = (r_state == S_IDLE) ? {ACC_SIZE{1'b0}} : r_acc[j];
        assign w_next[j] = w_base + ACC_SIZE'(w_beat[j]);
    end

    assign sat_flag = '0;
`endif

    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_flat[j*ACC_SIZE +: ACC_SIZE] = r_out[j];
    end

    assign in_accept = (r_state != S_DONE);
    assign mac_ready = (r_state == S_DONE);
    assign w_take    = in_ready && in_accept;
    assign w_n_sel   = (num_beats == '0)            ? CW'(1) :
                       (num_beats > CW'(MAX_BEATS)) ? CW'(MAX_BEATS) : num_beats;
    assign w_to_done = w_take && ((r_state == S_IDLE) ? (w_n_sel == CW'(1))
                                                      : (r_cnt + CW'(1) == r_n));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_next = w_to_done ? S_DONE : S_ACCUM;
            S_ACCUM: if (w_to_done) w_state_next = S_DONE;
            S_DONE:  if (out_ack) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_n   <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= '0;
                r_out[j] <= '0;
            end
`ifdef MAC_SAT_EN
            r_sat <= '0;
`endif
        end else if (w_take) begin
            if (r_state == S_IDLE) begin
                r_n   <= w_n_sel;
                r_cnt <= CW'(1);
`ifdef MAC_SAT_EN
                r_sat <= w_clamp;
`endif
            end else begin
                r_cnt <= r_cnt + CW'(1);
`ifdef MAC_SAT_EN
                r_sat <= r_sat | w_clamp;
`endif
            end
            for (int j = 0; j < N_OUT; j++) begin
                r_acc[j] <= w_next[j];
                if (w_to_done) r_out[j] <= w_next[j];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_acc_array.sv
// ============================================================================
// Module   : tb_mac_acc_array
// Purpose  : Directed self-checking bench for mac_acc_array (16-bit and 12-bit
//            accumulator instances driven in lockstep).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_acc_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_ready;
    logic [3:0]  num_beats;
    logic [19:0] x_flat;
    logic [79:0] w_flat;
    logic        out_ack;

    logic        in_accept, mac_ready;
    logic [63:0] out_flat;
    logic [3:0]  sat_flag;
    logic        in_accept12, mac_ready12;
    logic [47:0] out_flat12;
    logic [3:0]  sat_flag12;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_acc_array u_dut (
        .clk(clk), .rst(rst), .in_ready(in_ready), .in_accept(in_accept),
        .num_beats(num_beats), .x_flat(x_flat), .w_flat(w_flat),
        .out_flat(out_flat), .mac_ready(mac_ready), .out_ack(out_ack),
        .sat_flag(sat_flag)
    );

    mac_acc_array #(.ACC_SIZE(12)) u_dut12 (
        .clk(clk), .rst(rst), .in_ready(in_ready), .in_accept(in_accept12),
        .num_beats(num_beats), .x_flat(x_flat), .w_flat(w_flat),
        .out_flat(out_flat12), .mac_ready(mac_ready12), .out_ack(out_ack),
        .sat_flag(sat_flag12)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        x_flat = {5'(d), 5'(c), 5'(b), 5'(a)};
    endtask

    task automatic set_w_all(input int v);
        for (int k = 0; k < 16; k++) w_flat[k*5 +: 5] = 5'(v);
    endtask

    task automatic ack();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_ready = 1'b0; num_beats = '0; x_flat = '0; w_flat = '0; out_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_mac_ready", 64'(mac_ready), 64'd0);
        check("rst_in_accept", 64'(in_accept), 64'd1);
        check("rst_sat_flag",  64'(sat_flag),  64'd0);
        check("rst_out_flat",  out_flat,       64'd0);

        // Single beat: 1+2+3+4 with unit weights
        set_x(1, 2, 3, 4); set_w_all(1); num_beats = 4'd1; in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        check("single_ready",  64'(mac_ready), 64'd1);
        check("single_accept", 64'(in_accept), 64'd0);
        check("single_y",      out_flat,       {4{16'd10}});
        ack();
        check("single_ack_ready",  64'(mac_ready), 64'd0);
        check("single_ack_accept", 64'(in_accept), 64'd1);

        // Three beats of 1024 with one idle gap
        set_x(-16, -16, -16, -16); set_w_all(-16); num_beats = 4'd3;
        in_ready = 1'b1; step();
        in_ready = 1'b0; step();
        in_ready = 1'b1; step();
        check("three_ready_early", 64'(mac_ready), 64'd0);
        step();
        in_ready = 1'b0;
        check("three_ready",   64'(mac_ready),   64'd1);
        check("three_y",       out_flat,         {4{16'd3072}});
        check("three_sat",     64'(sat_flag),    64'd0);
        check("ovf_ready",     64'(mac_ready12), 64'd1);
        check("ovf_accept",    64'(in_accept12), 64'd0);
`ifdef MAC_SAT_EN
        check("ovf_y",   64'(out_flat12), {4{12'd2047}});
        check("ovf_sat", 64'(sat_flag12), 64'hF);
`else
        check("ovf_y",   64'(out_flat12), {4{12'hC00}});
        check("ovf_sat", 64'(sat_flag12), 64'h0);
`endif

        // Backpressure: beat offered while result waits for ack
        set_x(1, 1, 1, 1); set_w_all(1); num_beats = 4'd1; in_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_accept", 64'(in_accept), 64'd0);
            check("bp_ready",  64'(mac_ready), 64'd1);
            check("bp_hold",   out_flat,       {4{16'd3072}});
        end
        ack();
        check("bp_ack_ready",  64'(mac_ready), 64'd0);
        check("bp_ack_accept", 64'(in_accept), 64'd1);
        step();
        in_ready = 1'b0;
        check("bp_fresh_ready", 64'(mac_ready), 64'd1);
        check("bp_fresh_y",     out_flat,       {4{16'd4}});
        ack();

        // Reset after 2 of 4 beats
        set_x(-16, -16, -16, -16); set_w_all(-16); num_beats = 4'd4; in_ready = 1'b1;
        step(); step();
        in_ready = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_ready",  64'(mac_ready), 64'd0);
        check("midrst_accept", 64'(in_accept), 64'd1);
        set_x(1, 0, 0, 0); w_flat = '0;
        for (int j = 0; j < 4; j++) w_flat[j*5 +: 5] = 5'(j);
        num_beats = 4'd1; in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        check("midrst_job_ready", 64'(mac_ready), 64'd1);
        check("midrst_job_y",     out_flat,       {16'd3, 16'd2, 16'd1, 16'd0});
        ack();

        // num_beats = 0 behaves as a single beat
        set_x(1, 2, 3, 4); set_w_all(1); num_beats = 4'd0; in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        check("zero_ready", 64'(mac_ready), 64'd1);
        check("zero_y",     out_flat,       {4{16'd10}});
        ack();

        // num_beats = 15 clamps to 8; later num_beats changes are ignored
        set_x(1, 0, 0, 0); set_w_all(1); num_beats = 4'd15; in_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            step();
            num_beats = 4'd1;
            check("clamp_not_done", 64'(mac_ready), 64'd0);
        end
        step();
        in_ready = 1'b0;
        check("clamp_ready", 64'(mac_ready), 64'd1);
        check("clamp_y",     out_flat,       {4{16'd8}});
        ack();
        check("clamp_ack_ready", 64'(mac_ready), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_acc_array.md
# mac_acc_array

Parametrised, multi-beat accumulating MAC array for the GNN datapath: computes y(j) = Σ_beats Σ_i x(i)·w(i,j) for N_OUT output channels over N_IN inputs. It accumulates across a runtime-selected number of input beats to cover feature vectors wider than N_IN. The result is held under a valid/ack handshake with backpressure to the downstream aggregation stage. It is the generalised successor of the fixed 4x4 single-beat MAC.

## Interface
- N_IN, 4, input elements per beat
- N_OUT, 4, output channels
- MAC_IN_SIZE, 5, signed x element width
- W_SIZE, 5, signed weight width
- ACC_SIZE, 16, signed accumulator/output width
- MAX_BEATS, 8, maximum beats per job; CW = $clog2(MAX_BEATS+1)
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_ready  in  1  beat valid
- in_accept  out  1  block can take a beat
- num_beats  in  CW  beats in job, sampled on first beat only
- x_flat  in  N_IN*MAC_IN_SIZE  x(i) at [i*MAC_IN_SIZE +: MAC_IN_SIZE]
- w_flat  in  N_IN*N_OUT*W_SIZE  w(i,j) at [(i*N_OUT+j)*W_SIZE +: W_SIZE]
- out_flat  out  N_OUT*ACC_SIZE  y(j) at [j*ACC_SIZE +: ACC_SIZE]
- mac_ready  out  1  result valid
- out_ack  in  1  downstream consumed result
- sat_flag  out  N_OUT  sticky per-channel saturation indicator

## Operation
- Beat accepted on the rising edge where in_ready && in_accept. in_accept = 1 in IDLE/ACCUM, 0 in DONE.
- Beat sum per channel: full-precision signed Σ_i x(i)·w(i,j), width MAC_IN_SIZE+W_SIZE+$clog2(N_IN). It is sign-extended before being added.
- FSM:
  - IDLE: on an accepted beat, latch n = max(num_beats,1), acc(j) <= beat sum (not added to the old value), sat_flag cleared, cnt <= 1. Go to DONE if n==1, else ACCUM.
  - ACCUM: on an accepted beat, acc(j) <= acc(j)+beat sum and cnt++. Go to DONE when cnt+1 == n. With in_ready low, hold everything.
  - DONE: mac_ready=1, out_flat=acc, all values stable. On out_ack go to IDLE.
- num_beats > MAX_BEATS: clamp n to MAX_BEATS.
- Without saturation, adds wrap modulo 2^ACC_SIZE.
- Reset (any state, including mid-job): state IDLE, acc=0, cnt=0, mac_ready=0, sat_flag=0. The partial job is discarded.
- out_ack outside DONE is ignored.

## Timing
- Last beat accepted at edge t: mac_ready=1 and out_flat valid after edge t (1-cycle latency). The result holds until ack.
- out_ack sampled high at edge u in DONE: mac_ready=0 and in_accept=1 after u. The next beat can be accepted at edge u+1 at the earliest.
- out_flat is registered and holds its last value in IDLE/ACCUM. It is only meaningful while mac_ready=1.
- Minimum job period: n+1 cycles.

## Configuration
- MAC_SAT_EN defined: each beat's add clamps to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1]. Any clamp sets sat_flag(j). sat_flag(j) stays set until the next job's first beat or reset.
- MAC_SAT_EN undefined: two's-complement wrap, and sat_flag is tied to 0.

## Test plan
- Single beat: num_beats=1, x={1,2,3,4}, all w=1 → after one cycle mac_ready=1 and all y(j)=10. Ack → mac_ready=0 next cycle.
- Three beats: x all -16, w all -16, in_ready with one idle gap cycle → 1024/beat, so y(j)=3072 with mac_ready 1 cycle after the third beat.
- Overflow with ACC_SIZE=12, same stimulus as above:
  - MAC_SAT_EN defined: y=2047 and sat_flag=4'hF.
  - MAC_SAT_EN undefined: y=-1024 and sat_flag=0.
- Backpressure: hold out_ack=0 for 5 cycles with in_ready=1 → in_accept=0, no accumulation, out_flat unchanged. Ack → the next beat starts a fresh job whose result equals that beat alone.
- Reset mid-job: rst pulsed after 2 of 4 beats → mac_ready=0. A following 1-beat job with x={1,0,0,0} and w(0,j)=j gives y={0,1,2,3}.
- num_beats=0 → treated as 1. num_beats=15 (MAX_BEATS=8) → done after 8 beats.
